// File: rtl/posit_round_pipe.sv
// Packs an unpacked posit (sign, regime k, exponent, significand) into an N-bit posit with RNE/RTZ rounding.
// Latency 3 cycles, 1/cycle; all stages stall together while out_valid & ~out_ready (in_ready low).
module posit_round_pipe #(
  parameter int N  = 8,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic                 in_zero,
  input  logic                 in_nar,
  input  logic signed [RS:0]   in_k,
  input  logic [ES-1:0]        in_exp,
  input  logic [2*N-1:0]       in_frac,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_posit,
  output logic                 out_inexact
);

  localparam int XW = 3*N + ES;

  typedef struct packed {
    logic            sign;
    logic            zero;
    logic            nar;
    logic            mode;
    logic            maxp;
    logic            minp;
    logic            rpos;
    logic [RS:0]     fill;
    logic [ES-1:0]   exp;
    logic [2*N-2:0]  frac;
  } s1_t;

  typedef struct packed {
    logic            sign;
    logic            zero;
    logic            nar;
    logic            mode;
    logic            maxp;
    logic            minp;
    logic [N-2:0]    kept;
    logic            g;
    logic            s;
  } s2_t;

  logic          s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
  s1_t           s1_q, s1_d;
  s2_t           s2_q, s2_d;
  logic [N-1:0]  posit_q, posit_d;
  logic          inexact_q, inexact_d;
  logic          advance;
  int            k_i;
  logic [XW-1:0] str_full, str_sh;
  logic [RS:0]   shamt;
  logic [N-1:0]  sum;
  logic [N-2:0]  mag;
  logic          up, rnd_inexact;
  logic          unused_hidden;

  // The hidden bit is implied by the regime terminator, so it never enters the string.
  assign unused_hidden = in_frac[2*N-1];

  assign advance     = ~s3_vld_q | out_ready;
  assign in_ready    = advance;
  assign out_valid   = s3_vld_q;
  assign out_posit   = posit_q;
  assign out_inexact = inexact_q;

  always_comb begin
    k_i      = int'(in_k);
    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    if (advance) begin
      s1_vld_d   = in_valid;
      s1_d.sign  = in_sign;
      s1_d.zero  = in_zero;
      s1_d.nar   = in_nar;
      s1_d.mode  = in_mode;
      s1_d.maxp  = (k_i > N-2);
      s1_d.minp  = (k_i < -(N-2));
      s1_d.rpos  = (k_i >= 0);
      s1_d.fill  = (k_i >= 0) ? (RS+1)'(k_i + 1) : (RS+1)'(-k_i);
      s1_d.exp   = in_exp;
      s1_d.frac  = in_frac[2*N-2:0];
    end
  end

  // N copies of the regime fill bit sit on top; shifting left leaves exactly 'fill' of them.
  always_comb begin
    str_full = {{N{s1_q.rpos}}, ~s1_q.rpos, s1_q.exp, s1_q.frac};
    shamt    = (RS+1)'(N) - s1_q.fill;
    str_sh   = str_full << shamt;
    s2_vld_d = s2_vld_q;
    s2_d     = s2_q;
    if (advance) begin
      s2_vld_d  = s1_vld_q;
      s2_d.sign = s1_q.sign;
      s2_d.zero = s1_q.zero;
      s2_d.nar  = s1_q.nar;
      s2_d.mode = s1_q.mode;
      s2_d.maxp = s1_q.maxp;
      s2_d.minp = s1_q.minp;
      s2_d.kept = str_sh[XW-1 -: N-1];
      s2_d.g    = str_sh[XW-N];
      s2_d.s    = |str_sh[XW-N-1:0];
    end
  end

  always_comb begin
    up          = ~s2_q.mode & s2_q.g & (s2_q.s | s2_q.kept[0]);
    sum         = {1'b0, s2_q.kept} + N'(up);
    mag         = sum[N-1] ? '1 : sum[N-2:0];
    rnd_inexact = s2_q.g | s2_q.s;
    if (mag == '0) mag = (N-1)'(1);
    if (s2_q.maxp) begin
      mag         = '1;
      rnd_inexact = 1'b1;
    end else if (s2_q.minp) begin
      mag         = (N-1)'(1);
      rnd_inexact = 1'b1;
    end
    s3_vld_d  = s3_vld_q;
    posit_d   = posit_q;
    inexact_d = inexact_q;
    if (advance) begin
      s3_vld_d  = s2_vld_q;
      posit_d   = s2_q.sign ? (~{1'b0, mag} + N'(1)) : {1'b0, mag};
      inexact_d = rnd_inexact;
      if (s2_q.nar) begin
        posit_d   = {1'b1, {(N-1){1'b0}}};
        inexact_d = 1'b0;
      end else if (s2_q.zero) begin
        posit_d   = '0;
        inexact_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      posit_q   <= '0;
      inexact_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      s3_vld_q  <= s3_vld_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      posit_q   <= posit_d;
      inexact_q <= inexact_d;
    end
  end

endmodule

// File: tb/tb_posit_round_pipe.sv
// Randomised and directed bench for posit_round_pipe against a bit-queue reference of the posit encoding.
module tb_posit_round_pipe;
  localparam int N  = 8;
  localparam int ES = 2;
  localparam int RS = $clog2(N);

  logic                clk = 1'b0;
  logic                rst_n, in_valid, in_ready, in_sign, in_zero, in_nar, in_mode;
  logic                out_valid, out_ready, out_inexact;
  logic signed [RS:0]  in_k;
  logic [ES-1:0]       in_exp;
  logic [2*N-1:0]      in_frac;
  logic [N-1:0]        out_posit;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_acc = 0;
  logic [N:0] exp_q[$];
  logic [N:0] hold_val;
  logic [N:0] e_pop;
  logic       hold_vld = 1'b0;
  logic       done = 1'b0;

  posit_round_pipe #(.N(N), .ES(ES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_zero(in_zero), .in_nar(in_nar),
    .in_k(in_k), .in_exp(in_exp), .in_frac(in_frac), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_posit(out_posit), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // Reference: literally write out regime|exp|fraction as a bit sequence and cut it.
  function automatic logic [N:0] model(input logic sg, input logic zr, input logic nr, input int k,
                                       input int e, input logic [2*N-1:0] fr, input logic md);
    bit          q[$];
    int unsigned mag, maxpos;
    logic        g, s, inx;
    logic [N-1:0] p;
    maxpos = (1 << (N-1)) - 1;
    if (nr) begin
      p = '0;
      p[N-1] = 1'b1;
      return {1'b0, p};
    end
    if (zr) return '0;
    inx = 1'b1;
    if (k > N-2) mag = maxpos;
    else if (k < -(N-2)) mag = 1;
    else begin
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = ES-1; i >= 0; i--) q.push_back(e[i]);
      for (int i = 2*N-2; i >= 0; i--) q.push_back(fr[i]);
      mag = 0;
      for (int i = 0; i < N-1; i++) mag = mag*2 + q[i];
      g = q[N-1];
      s = 1'b0;
      for (int i = N; i < q.size(); i++) s |= q[i];
      if (!md && g && (s || mag[0])) mag++;
      if (mag > maxpos) mag = maxpos;
      if (mag == 0) mag = 1;
      inx = g | s;
    end
    p = N'(mag);
    if (sg) p = N'(0) - p;
    return {inx, p};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) hold_vld = 1'b0;
    else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (hold_vld) begin
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_data", 32'({out_inexact, out_posit}), 32'(hold_val));
      end
      hold_vld = out_valid && !out_ready;
      hold_val = {out_inexact, out_posit};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_output: got posit 0x%0h, required no output", out_posit);
        end else begin
          e_pop = exp_q.pop_front();
          chk("result", 32'({out_inexact, out_posit}), 32'(e_pop));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_sign, in_zero, in_nar, int'(in_k), int'(in_exp), in_frac, in_mode));
        n_acc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the input.
  task automatic send(input logic sg, input logic zr, input logic nr, input int k, input int e,
                      input logic [2*N-1:0] fr, input logic md);
    logic ok;
    int   t;
    in_sign = sg; in_zero = zr; in_nar = nr; in_mode = md;
    in_k = (RS+1)'(k); in_exp = ES'(e); in_frac = fr;
    in_valid = 1'b1;
    ok = 1'b0;
    t = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready;
      step();
      t++;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required acceptance");
    end
  endtask

  task automatic drain(input string nm);
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) step();
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic lat_check(input string nm);
    send(1'b0, 1'b0, 1'b0, 0, 0, 16'h8000, 1'b0);
    in_valid = 1'b0;
    @(negedge clk) chk({nm, "_c1"}, 32'(out_valid), 32'(0));
    @(negedge clk) chk({nm, "_c2"}, 32'(out_valid), 32'(0));
    @(negedge clk) chk({nm, "_c3"}, 32'(out_valid), 32'(1));
    chk({nm, "_posit"}, 32'(out_posit), 32'(8'h40));
    chk({nm, "_inexact"}, 32'(out_inexact), 32'(0));
    step();
  endtask

  initial begin
    logic [2*N-1:0] fr;
    int             acc0;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
    in_k = '0; in_exp = '0; in_frac = '0; in_mode = 1'b0; out_ready = 1'b1;

    chk("pin_one",      32'(model(0, 0, 0,  0, 0, 16'h8000, 0)), 32'(9'h040));
    chk("pin_neg_one",  32'(model(1, 0, 0,  0, 0, 16'h8000, 0)), 32'(9'h0C0));
    chk("pin_tie_even", 32'(model(0, 0, 0,  0, 0, 16'h8800, 0)), 32'(9'h140));
    chk("pin_tie_odd",  32'(model(0, 0, 0,  0, 0, 16'h9800, 0)), 32'(9'h142));
    chk("pin_rtz",      32'(model(0, 0, 0,  0, 0, 16'h9800, 1)), 32'(9'h141));
    chk("pin_maxpos",   32'(model(0, 0, 0,  7, 0, 16'h8000, 0)), 32'(9'h17F));
    chk("pin_minpos",   32'(model(0, 0, 0, -8, 0, 16'h8000, 0)), 32'(9'h101));
    chk("pin_negmax",   32'(model(1, 0, 0,  7, 0, 16'h8000, 0)), 32'(9'h181));
    chk("pin_nar",      32'(model(0, 1, 1,  0, 0, 16'h8000, 0)), 32'(9'h080));
    chk("pin_zero",     32'(model(1, 1, 0,  0, 0, 16'h8000, 0)), 32'(9'h000));
    chk("pin_k6_exact", 32'(model(0, 0, 0,  6, 0, 16'h8000, 0)), 32'(9'h07F));

    #3;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_posit", 32'(out_posit), 32'(0));
    chk("rst_out_inexact", 32'(out_inexact), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    lat_check("lat");

    send(0, 0, 0,  0, 0, 16'h8000, 0);
    send(1, 0, 0,  0, 0, 16'h8000, 0);
    send(0, 0, 0,  0, 0, 16'h8800, 0);
    send(0, 0, 0,  0, 0, 16'h9800, 0);
    send(0, 0, 0,  0, 0, 16'h9800, 1);
    send(0, 0, 0,  7, 0, 16'h8000, 0);
    send(0, 0, 0, -8, 0, 16'h8000, 0);
    send(1, 0, 0,  7, 0, 16'h8000, 0);
    send(0, 1, 1,  0, 0, 16'h8000, 0);
    send(1, 1, 0,  0, 0, 16'h8000, 0);
    send(0, 0, 0,  6, 0, 16'h8000, 0);
    send(0, 0, 0,  6, 3, 16'hFFFF, 0);
    send(1, 0, 0, -6, 3, 16'hC000, 0);
    send(0, 0, 0, -7, 0, 16'h8000, 1);
    in_valid = 1'b0;
    drain("dir");

    out_ready = 1'b0;
    acc0 = n_acc;
    fork
      begin
        send(0, 0, 0,  1, 1, 16'hA000, 0);
        send(1, 0, 0, -2, 2, 16'hF123, 0);
        send(0, 0, 0,  3, 3, 16'h8001, 1);
        send(1, 0, 0,  0, 0, 16'h9800, 0);
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_accepts", 32'(n_acc - acc0), 32'(3));
        chk("bp_in_ready", 32'(in_ready), 32'(0));
        chk("bp_out_valid", 32'(out_valid), 32'(1));
        step();
        out_ready = 1'b1;
      end
    join
    drain("bp");

    send(0, 0, 0, 2, 1, 16'h8400, 0);
    send(1, 0, 0, 1, 2, 16'h8C00, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("arst_pre_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_out_posit", 32'(out_posit), 32'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) chk("arst_quiet", 32'(out_valid), 32'(0));
      step();
    end
    lat_check("lat_after_rst");

    fork
      begin
        for (int i = 0; i < 400; i++) begin
          fr = {1'b1, (2*N-1)'($urandom)};
          if ($urandom_range(0, 2) == 0) fr &= ~(((2*N)'(1) << $urandom_range(0, 2*N-1)) - (2*N)'(1));
          send(1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 15) - 8, int'($urandom_range(0, (1 << ES) - 1)), fr, 1'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) step();
          end
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    out_ready = 1'b1;
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/posit_round_pipe.md
Name: posit_round_pipe

Overview:
Parametrised, pipelined successor to the posit multiplier's combinational rounding/encode stage. Takes an unpacked posit result (sign, regime value k, exponent, normalised fraction, special flags) and packs it into an N-bit posit. Rounding mode is selectable per transaction (round-to-nearest-even or toward-zero), with saturation and an inexact flag. Three register stages sit behind a valid/ready handshake, so it can be placed between the multiplier datapath and the result bus.

Parameters:
N, 8, posit width in bits (N >= 5)
ES, 2, exponent field width (ES <= N-3)
RS, $clog2(N), regime index width; in_k is RS+1 bits signed

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
in_sign  in  1  result sign (1 = negative)
in_zero  in  1  result is exact zero
in_nar  in  1  result is NaR (inf); takes priority over in_zero
in_k  in  RS+1  signed regime value
in_exp  in  ES  exponent field
in_frac  in  2N  normalised significand; bit 2N-1 is hidden 1, bits 2N-2:0 are fraction
in_mode  in  1  0 = round-nearest-even, 1 = round-toward-zero
out_valid  out  1  output posit valid
out_ready  in  1  downstream accepts output
out_posit  out  N  encoded posit, two's complement when negative
out_inexact  out  1  discarded bits were non-zero (0 for zero/NaR)

Behaviour:
- Reset (rst_n low, async): all stage valid bits clear; out_valid=0, out_posit=0, out_inexact=0. Pipeline data registers clear to 0. Reset mid-flight drops all in-flight transactions; none reappear after release.
- Handshake: advance = ~out_valid | out_ready; in_ready = advance. All three stages load only when advance=1, so the pipeline moves as a whole. Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready. A bubble (in_valid=0 while advancing) shifts a cleared valid bit through the pipeline.
- Latency: exactly 3 cycles from the accepted input to out_valid under continuous out_ready. Throughput 1 per cycle. While out_ready=0 and out_valid=1, out_posit and out_inexact hold stable and in_ready=0.
- Stage 1: register inputs. Clamp: if k > N-2, force maxpos path. If k < -(N-2), force minpos path. Compute regime length: k>=0 gives k+1 ones then a 0; k<0 gives -k zeros then a 1.
- Stage 2: form the unbounded magnitude string regime|exp|in_frac[2N-2:0]. Right-align it into N-1 magnitude bits. Extract L (LSB kept), G (first dropped bit), S (OR of all remaining dropped bits).
- Stage 3: RNE: up = G & (S | L). RTZ: up = 0. mag = kept + up, with no wrap: a carry past maxpos saturates to maxpos (all ones, N-1 bits). A magnitude of 0 from a non-zero input becomes minpos (...001). out_inexact = G | S. Output = {0, mag}, two's-complemented when the sign is set.
- Specials: in_nar gives 1 followed by N-1 zeros. Otherwise in_zero gives all zeros. Both give inexact=0 and the sign is ignored. A value is never rounded to zero or NaR.
- Clamp paths: the maxpos path gives magnitude all ones and the minpos path gives magnitude 1; inexact=1 in both unless the value is exactly representable (k=N-2 with exp and fraction zero gives maxpos, inexact=0).

Test Plan:
- N=8,ES=2: k=0, exp=0, in_frac=16'h8000, sign=0 -> out_posit=8'h40, inexact=0, out_valid exactly 3 cycles after accept. Same input with sign=1 -> 8'hC0.
- Tie handling, k=0, exp=0: in_frac=16'h8800, RNE -> 8'h40, inexact=1. in_frac=16'h9800, RNE -> 8'h42. in_frac=16'h9800, RTZ -> 8'h41.
- Saturation: k=7 (in_k=4'sd7) -> 8'h7F. k=-8 -> 8'h01. Sign=1 with k=7 -> 8'h81. Inexact=1 in all three.
- Specials: in_nar=1 with in_zero=1 -> 8'h80, inexact=0. in_zero=1 only, sign=1 -> 8'h00.
- Back-pressure: 4 inputs back-to-back with out_ready=0 -> in_ready falls after 3 accepts, the 4th is held, out_posit stays stable. Raising out_ready drains results in order, 1 per cycle, with none lost or duplicated.
- Async reset: assert rst_n=0 mid-stream with 2 transactions in flight -> out_valid=0 immediately without a clock edge. After release, no stale outputs appear and the first new input emerges 3 cycles later.
